// File: rtl/rand_dispatch.sv
// rand_dispatch: round-robin sharing of one 16-bit LFSR among N_REQ requesters.
// Sequences generator seeding and enforces refill spacing between grants.
module rand_dispatch #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned SPACING      = 16,
    parameter logic [15:0] DEFAULT_SEED = 16'h0000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_reseed,
    input  logic [15:0]      i_seed,
    input  logic [15:0]      i_rng_value,
    output logic             o_rng_rst,
    output logic [15:0]      o_rng_seed,
    output logic [N_REQ-1:0] o_ack,
    output logic [15:0]      o_data,
    output logic             o_ready
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(SPACING + 1);
    localparam int NR = int'(N_REQ);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SPACING - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_SEED,
        S_FILL,
        S_READY,
        S_GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [15:0]      seed_q, seed_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [15:0]      data_q, data_d;

    logic             found;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    ptr_next;
    int               rr_idx;

    // Round-robin search: first requester at or above ptr, wrapping to 0.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        cand   = '0;
        rr_idx = 0;
        for (int i = 0; i < NR; i++) begin
            rr_idx = int'(ptr_q) + i;
            if (rr_idx >= NR) rr_idx = rr_idx - NR;
            cand = PW'(rr_idx);
            if (!found && i_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        ptr_next = (pick == PTR_LAST) ? '0 : pick + 1'b1;
    end

    // Next-state logic; a reseed overrides any transition or grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        seed_d  = seed_q;
        ack_d   = '0;
        data_d  = '0;
        unique case (state_q)
            S_SEED: begin
                state_d = S_FILL;
                cnt_d   = CNT_LOAD;
            end
            S_FILL: begin
                if (cnt_q == '0) state_d = S_READY;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_READY: begin
                if (found) begin
                    ack_d[pick] = 1'b1;
                    data_d      = i_rng_value;
                    ptr_d       = ptr_next;
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                state_d = S_FILL;
                cnt_d   = CNT_LOAD;
            end
            default: state_d = S_SEED;
        endcase
        if (i_reseed) begin
            seed_d  = i_seed;
            state_d = S_SEED;
            ack_d   = '0;
            data_d  = '0;
            ptr_d   = ptr_q;
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_SEED;
            cnt_q   <= '0;
            ptr_q   <= '0;
            seed_q  <= DEFAULT_SEED;
            ack_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            seed_q  <= seed_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
        end
    end

    assign o_rng_rst  = i_rst | (state_q == S_SEED);
    assign o_rng_seed = seed_q;
    assign o_ack      = ack_q;
    assign o_data     = data_q;
    assign o_ready    = (state_q == S_READY);

endmodule
